alu_pipe_flags: RTL and testbench

- Parametrised, 2-stage pipelined successor to the single-cycle 16-bit ALU, with valid/ready handshakes on input and output.
- Holds the architectural Z/V/N flag register internally and commits it in program order only when a result is consumed.
- Adds a pipeline flush, an illegal-op indication and optional saturating ADD/SUB.
- Sits between decode/register-read and writeback in the pipelined core.

---
 rtl/alu_pipe_flags.sv | 171 +++++++++++++++++
 tb/tb_alu_pipe_flags.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_flags.sv
// Two-stage pipelined ALU with valid/ready handshakes, flush, illegal-op flag and an
// in-order committed Z/V/N flag register. Define ALU_SAT_EN for saturating ADD/SUB.

module alu_paddsb_lane #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] sum_o
);
    logic [LANE_W-1:0] raw;
    logic              ovf;

    always_comb begin
        raw   = a_i + b_i;
        ovf   = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (raw[LANE_W-1] != a_i[LANE_W-1]);
        sum_o = raw;
        if (ovf)
            sum_o = a_i[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
endmodule

module alu_pipe_flags #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flags,
    output logic [2:0]        flags_wr,
    output logic              illegal_op
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int NLANE = DATA_W / LANE_W;
    localparam int NBYTE = DATA_W / 8;
    localparam int HALF  = DATA_W / 2;
    localparam int MSB   = DATA_W - 1;

    localparam logic [3:0] OP_RED = 4'b0000, OP_SLL = 4'b0001, OP_SRA = 4'b0010,
                           OP_PAD = 4'b0011, OP_ROR = 4'b0100, OP_LW  = 4'b0101,
                           OP_SW  = 4'b0110, OP_LHB = 4'b0111, OP_LLB = 4'b1000,
                           OP_ADD = 4'b1001, OP_SUB = 4'b1010, OP_XOR = 4'b1011;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    // cand/wr are ordered {Z,V,N} to line up with the flag register
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [2:0]        cand;
        logic [2:0]        wr;
        logic              ill;
    } rsp_t;

    logic [2:1] vld_pipe_q, vld_pipe_d;
    req_t       s1_q, s1_d;
    rsp_t       s2_q, s2_d;
    logic [2:0] flags_q, flags_d;
    logic       adv, accept, commit, s2_load;

    assign adv       = !vld_pipe_q[2] | out_ready;
    assign in_ready  = !flush & (!vld_pipe_q[1] | adv);
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_pipe_q[2] & !flush;
    assign commit    = out_valid & out_ready;
    assign s2_load   = !flush & adv & vld_pipe_q[1];

    assign s1_d = '{op: alu_op, a: src1, b: src2};

    logic [NLANE-1:0][LANE_W-1:0] lane_sum;
    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        alu_paddsb_lane #(.LANE_W(LANE_W)) u_lane (
            .a_i   (s1_q.a[g*LANE_W +: LANE_W]),
            .b_i   (s1_q.b[g*LANE_W +: LANE_W]),
            .sum_o (lane_sum[g])
        );
    end

    logic [SH_W-1:0]          sh;
    logic signed [DATA_W-1:0] red_sum;
    logic [DATA_W-1:0]        ror_res, b_eff, addsub_raw, addsub_res;
    logic                     is_sub, ovf;

    assign sh = s1_q.a[SH_W-1:0];

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < NBYTE; i++)
            red_sum = red_sum + DATA_W'($signed(s1_q.a[8*i +: 8]))
                              + DATA_W'($signed(s1_q.b[8*i +: 8]));
        ror_res = '0;
        for (int i = 0; i < DATA_W; i++)
            ror_res[i] = s1_q.b[(i + int'(sh)) % DATA_W];
    end

    // Subtraction reuses the adder as a + ~b + 1, so one overflow rule covers both
    always_comb begin
        is_sub     = (s1_q.op == OP_SUB);
        b_eff      = is_sub ? ~s1_q.b : s1_q.b;
        addsub_raw = s1_q.a + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
        ovf        = (s1_q.a[MSB] == b_eff[MSB]) && (addsub_raw[MSB] != s1_q.a[MSB]);
`ifdef ALU_SAT_EN
        addsub_res = addsub_raw;
        if (ovf)
            addsub_res = s1_q.a[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
        addsub_res = addsub_raw;
`endif
    end

    always_comb begin
        s2_d = '0;
        unique case (s1_q.op)
            OP_RED:          s2_d.res = red_sum;
            OP_SLL:          begin s2_d.res = s1_q.b << sh;                       s2_d.wr = 3'b100; end
            OP_SRA:          begin s2_d.res = DATA_W'($signed(s1_q.b) >>> sh);    s2_d.wr = 3'b100; end
            OP_ROR:          begin s2_d.res = ror_res;                            s2_d.wr = 3'b100; end
            OP_PAD:          s2_d.res = lane_sum;
            OP_LW, OP_SW:    s2_d.res = (s1_q.b & ~DATA_W'(1)) + DATA_W'({s1_q.a[3:0], 1'b0});
            OP_LHB:          s2_d.res = {s1_q.a[HALF-1:0], s1_q.b[HALF-1:0]};
            OP_LLB:          s2_d.res = {s1_q.b[DATA_W-1:HALF], s1_q.a[HALF-1:0]};
            OP_ADD, OP_SUB:  begin s2_d.res = addsub_res; s2_d.wr = 3'b111; end
            OP_XOR:          begin s2_d.res = s1_q.a ^ s1_q.b;                    s2_d.wr = 3'b100; end
            default:         s2_d.ill = 1'b1;
        endcase
        s2_d.cand = {s2_d.res == '0, ovf, s2_d.res[MSB]};
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (flush) begin
            vld_pipe_d = '0;
        end else begin
            if (adv)         vld_pipe_d[2] = vld_pipe_q[1];
            if (accept)      vld_pipe_d[1] = 1'b1;
            else if (adv)    vld_pipe_d[1] = 1'b0;
        end
        flags_d = commit ? ((flags_q & ~s2_q.wr) | (s2_q.cand & s2_q.wr)) : flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            flags_q    <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            if (accept)  s1_q <= s1_d;
            if (s2_load) s2_q <= s2_d;
            flags_q    <= flags_d;
        end
    end

    assign result     = s2_q.res;
    assign flags      = flags_q;
    assign flags_wr   = s2_q.wr;
    assign illegal_op = s2_q.ill;
endmodule

// File: tb/tb_alu_pipe_flags.sv
// Scoreboard bench for alu_pipe_flags: directed cases plus randomized ops and back-pressure,
// checked against an integer-arithmetic reference model.

module tb_alu_pipe_flags;
    logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
    logic [3:0]  alu_op = 0;
    logic [15:0] src1 = 0, src2 = 0;
    logic        in_ready, out_valid, illegal_op;
    logic [15:0] result;
    logic [2:0]  flags, flags_wr;

    alu_pipe_flags #(.DATA_W(16), .LANE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .flags_wr(flags_wr), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  wr;
        logic        ill;
        logic [2:0]  cand;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_pass = 0;
    int   rdy_mode = 0;          // 0: always ready, 1: stalled, 2: random
    logic [2:0] exp_flags = 0;

`ifdef ALU_SAT_EN
    localparam logic [2:0] OVF_FLAGS = 3'b010;
`else
    localparam logic [2:0] OVF_FLAGS = 3'b011;
`endif

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int s, x, sa, sb;
        logic v;
        e.res = 0; e.wr = 0; e.ill = 0; e.cand = 0; v = 0;
        sa = $signed(a); sb = $signed(b);
        case (op)
            4'd0: begin
                s = 0;
                for (int i = 0; i < 2; i++) s = s + $signed(a[8*i +: 8]) + $signed(b[8*i +: 8]);
                e.res = s[15:0];
            end
            4'd1: begin e.res = b << a[3:0]; e.wr = 3'b100; end
            4'd2: begin s = sb >>> a[3:0]; e.res = s[15:0]; e.wr = 3'b100; end
            4'd4: begin
                e.res = b;
                for (int i = 0; i < int'(a[3:0]); i++) e.res = {e.res[0], e.res[15:1]};
                e.wr = 3'b100;
            end
            4'd3: for (int i = 0; i < 4; i++) begin
                x = $signed(a[4*i +: 4]) + $signed(b[4*i +: 4]);
                if (x > 7) x = 7;
                if (x < -8) x = -8;
                e.res[4*i +: 4] = x[3:0];
            end
            4'd5, 4'd6: e.res = (b & 16'hFFFE) + {11'd0, a[3:0], 1'b0};
            4'd7: e.res = {a[7:0], b[7:0]};
            4'd8: e.res = {b[15:8], a[7:0]};
            4'd9, 4'd10: begin
                s = (op == 4'd9) ? sa + sb : sa - sb;
                v = (s > 32767) || (s < -32768);
`ifdef ALU_SAT_EN
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
`endif
                e.res = s[15:0];
                e.wr = 3'b111;
            end
            4'd11: begin e.res = a ^ b; e.wr = 3'b100; end
            default: e.ill = 1;
        endcase
        e.cand = {e.res == 16'd0, v, e.res[15]};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        in_valid = 1; alu_op = op; src1 = a; src2 = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(op, a, b));
                break;
            end
            k++;
            if (k > 200) begin
                n_chk++;
                $display("FAIL issue_timeout op=%h", op);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        do begin @(negedge clk); k++; end while ((sb_q.size() != 0 || out_valid) && k < 300);
        if (k >= 300) begin
            n_chk++;
            $display("FAIL drain_timeout pending=%0d", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    // out_ready changes 2 time units after the edge so a mode change at +1 takes effect that cycle
    initial forever begin
        @(posedge clk); #2;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    initial forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (!rst_n) exp_flags = 0;
        else if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output result=%h", result);
            end else begin
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("flags_wr", 32'(flags_wr), 32'(e.wr));
                chk("illegal_op", 32'(illegal_op), 32'(e.ill));
                chk("flags_before_commit", 32'(flags), 32'(exp_flags));
                exp_flags = (exp_flags & ~e.wr) | (e.cand & e.wr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags_wr", 32'(flags_wr), 0);
        chk("rst_illegal", 32'(illegal_op), 0);
        @(posedge clk); #1;

        // overflowing add, with latency check on an empty pipe
        issue(4'd9, 16'h7FFF, 16'h0001);
        @(negedge clk); chk("lat_edge1_out_valid", 32'(out_valid), 0);
        @(negedge clk); chk("lat_edge2_out_valid", 32'(out_valid), 1);
        drain();
        chk("add_ovf_flags", 32'(flags), 32'(OVF_FLAGS));

        issue(4'd10, 16'h1234, 16'h1234);
        drain();
        chk("sub_zero_flags", 32'(flags), 32'(3'b100));
        issue(4'd8, 16'h00AB, 16'hFF00);
        drain();
        chk("llb_flags_hold", 32'(flags), 32'(3'b100));

        // back-pressure: third op must wait
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(4'd9, 16'd1, 16'd1);
        issue(4'd9, 16'd2, 16'd2);
        in_valid = 1; alu_op = 4'd9; src1 = 16'd3; src2 = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("stall_in_ready", 32'(in_ready), 0);
        end
        rdy_mode = 0;
        issue(4'd9, 16'd3, 16'd3);
        drain();
        chk("stall_flags", 32'(flags), 0);

        issue(4'd3, 16'h7777, 16'h1111);
        issue(4'd3, 16'h8888, 16'hFFFF);
        drain();
        chk("paddsb_flags_hold", 32'(flags), 0);

        // flush two in-flight ops that would otherwise change the flags
        issue(4'd10, 16'd5, 16'd5);
        issue(4'd9, 16'h7FFF, 16'h0001);
        flush = 1;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 0);
        sb_q.delete();
        @(posedge clk); #1 flush = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("post_flush_out_valid", 32'(out_valid), 0);
        end
        chk("flush_flags_hold", 32'(flags), 0);
        @(posedge clk); #1;
        issue(4'd11, 16'h00FF, 16'h00FF);
        drain();
        chk("xor_zero_flags", 32'(flags), 32'(3'b100));

        issue(4'd15, 16'hBEEF, 16'h1234);
        drain();
        chk("illegal_flags_hold", 32'(flags), 32'(3'b100));

        // randomized ops under random back-pressure
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end
        rdy_mode = 0;
        drain();

        issue(4'd10, 16'd1, 16'd2);
        drain();
        chk("sub_neg_flags", 32'(flags), 32'(3'b001));

        // reset while an op sits stalled in S2
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(4'd9, 16'd3, 16'd4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("held_out_valid", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_flags", 32'(flags), 0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1;
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(4'd11, 16'h8000, 16'h0001);
        drain();
        chk("post_rst_flags", 32'(flags), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
